// File: rtl/tu_pkg.sv
// Shared types and helpers for the test-unit launch/supervise blocks.
//   tu_launch_st_e : launcher FSM states
//   tu_verdict_t   : registered pass/fail/abort verdict
//   tu_cnt_w(n)    : bits needed to hold the value n (never less than 1)
package tu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tu_launch_st_e;

    typedef struct packed {
        logic pass;
        logic fail;
        logic abort;
    } tu_verdict_t;

    function automatic int tu_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tu_cyc_timer.sv
// Clearable cycle up-counter with a terminal-count flag.
// Ports:
//   clock  : rising-edge clock
//   rst    : asynchronous active-high reset
//   clr    : synchronous clear (wins over en)
//   en     : count enable
//   tc_val : terminal count value
//   tc     : high while the count equals tc_val
module tu_cyc_timer #(
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] tc_val,
    output logic          tc
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/tu_pass_launch.sv
// Launch/supervise stage in front of a test-unit chain. Raises the chain's
// pass input, waits for the chain's return with a per-attempt timeout and a
// bounded number of retries, then reports a registered verdict. Its own
// from_up_pass gates everything so launchers can be chained.
// Ports:
//   clock, rst    : clock and asynchronous active-high reset
//   from_up_pass  : upstream permit; dropping it mid-run aborts
//   start         : single-cycle launch request
//   chain_ret     : pass level from the end of the downstream chain
//   to_down_pass  : level driven into the downstream chain
//   busy, done    : not-idle flag, one-cycle verdict pulse
//   pass/fail/abort, retry_cnt : sticky verdict and retries consumed
//   lat_cnt       : start-to-done cycles, only with TU_PASS_LAUNCH_STAT_EN
//
// state | meaning
// IDLE  | waiting for start while from_up_pass is high
// DRIVE | to_down_pass high, waiting for chain_ret or attempt timeout
// GAP   | to_down_pass low for GAP_CYC cycles before the next attempt
// DONE  | one-cycle verdict pulse, then back to IDLE
module tu_pass_launch
    import tu_pkg::*;
#(
    parameter int TIMEOUT   = 256,
    parameter int MAX_RETRY = 3,
    parameter int GAP_CYC   = 4,
    parameter int CW        = 16
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             from_up_pass,
    input  logic                             start,
    input  logic                             chain_ret,
    output logic                             to_down_pass,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             fail,
    output logic                             abort,
`ifdef TU_PASS_LAUNCH_STAT_EN
    output logic [CW-1:0]                    lat_cnt,
`endif
    output logic [tu_cnt_w(MAX_RETRY)-1:0]   retry_cnt
);

    localparam int RW = tu_cnt_w(MAX_RETRY);

    tu_launch_st_e state, state_nxt;
    tu_verdict_t   verdict_q, verdict_nxt;
    logic [RW-1:0] retry_q, retry_nxt;
    logic          tdp_nxt;
    logic          accept;
    logic          drive_tc, gap_tc;

    assign accept = (state == IDLE) && start && from_up_pass;

    // Both timers sit at zero outside their own state, so each attempt and
    // each gap starts counting from 0 on its first cycle.
    tu_cyc_timer #(.CW(CW)) u_drive_tmr (
        .clock  (clock),
        .rst    (rst),
        .clr    (state != DRIVE),
        .en     (state == DRIVE),
        .tc_val (CW'(TIMEOUT - 1)),
        .tc     (drive_tc)
    );

    tu_cyc_timer #(.CW(CW)) u_gap_tmr (
        .clock  (clock),
        .rst    (rst),
        .clr    (state != GAP),
        .en     (state == GAP),
        .tc_val (CW'(GAP_CYC - 1)),
        .tc     (gap_tc)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            verdict_q    <= '0;
            retry_q      <= '0;
            to_down_pass <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            verdict_q    <= verdict_nxt;
            retry_q      <= retry_nxt;
            to_down_pass <= tdp_nxt;
            busy         <= (state_nxt != IDLE);
            done         <= (state_nxt == DONE);
        end
    end

    // Priority inside DRIVE: abort, then chain pass, then timeout.
    always_comb begin
        state_nxt   = state;
        verdict_nxt = verdict_q;
        retry_nxt   = retry_q;
        tdp_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = DRIVE;
                    verdict_nxt = '0;
                    retry_nxt   = '0;
                    tdp_nxt     = 1'b1;
                end
            end
            DRIVE: begin
                if (!from_up_pass) begin
                    state_nxt         = DONE;
                    verdict_nxt.fail  = 1'b1;
                    verdict_nxt.abort = 1'b1;
                end else if (chain_ret) begin
                    state_nxt        = DONE;
                    verdict_nxt.pass = 1'b1;
                end else if (drive_tc) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        state_nxt = GAP;
                        retry_nxt = retry_q + RW'(1);
                    end else begin
                        state_nxt        = DONE;
                        verdict_nxt.fail = 1'b1;
                    end
                end else begin
                    tdp_nxt = 1'b1;
                end
            end
            GAP: begin
                if (!from_up_pass) begin
                    state_nxt         = DONE;
                    verdict_nxt.fail  = 1'b1;
                    verdict_nxt.abort = 1'b1;
                end else if (gap_tc) begin
                    state_nxt = DRIVE;
                    tdp_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign pass      = verdict_q.pass;
    assign fail      = verdict_q.fail;
    assign abort     = verdict_q.abort;
    assign retry_cnt = retry_q;

`ifdef TU_PASS_LAUNCH_STAT_EN
    // Loaded with 2 so the start cycle and the DONE cycle are both counted.
    logic [CW-1:0] lat_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            lat_q <= '0;
        else if (accept)
            lat_q <= CW'(2);
        else if (((state == DRIVE) || (state == GAP)) && (lat_q != '1))
            lat_q <= lat_q + CW'(1);
    end

    assign lat_cnt = lat_q;
`endif

endmodule

// File: tb/tb_tu_pass_launch.sv
module tb_tu_pass_launch;

    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 2;
    localparam int GAP_CYC   = 3;
    localparam int CW        = 16;
    localparam int P         = TIMEOUT + GAP_CYC;
    localparam int NONE      = 100000;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        from_up_pass = 1'b0;
    logic        start = 1'b0;
    logic        chain_ret = 1'b0;
    logic        to_down_pass, busy, done, pass, fail, abort;
    logic [1:0]  retry_cnt;
`ifdef TU_PASS_LAUNCH_STAT_EN
    logic [CW-1:0] lat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    tu_pass_launch #(
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC), .CW(CW)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .from_up_pass (from_up_pass),
        .start        (start),
        .chain_ret    (chain_ret),
        .to_down_pass (to_down_pass),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .abort        (abort),
`ifdef TU_PASS_LAUNCH_STAT_EN
        .lat_cnt      (lat_cnt),
`endif
        .retry_cnt    (retry_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Cycle t counts from the accepting edge: cycle 0 presents start,
    // attempt i drives cycles 1+i*P .. i*P+TIMEOUT, then GAP_CYC gap cycles.
    function automatic bit in_drive(input int t);
        int i, off;
        if (t < 1) return 1'b0;
        i   = (t - 1) / P;
        off = (t - 1) % P;
        return (i <= MAX_RETRY) && (off < TIMEOUT);
    endfunction

    function automatic bit in_gap(input int t);
        int i, off;
        if (t < 1) return 1'b0;
        i   = (t - 1) / P;
        off = (t - 1) % P;
        return (i < MAX_RETRY) && (off >= TIMEOUT);
    endfunction

    // Outcome from event times: the earliest of abort / pass / exhaustion
    // decides, ties resolved abort > pass > timeout.
    task automatic ref_model(input int a, input int k, input int t_ab,
                             output bit ep, output bit ef, output bit ea,
                             output int er, output int edt);
        int t_p, t_x, t_end, i, off;
        t_p   = (a <= MAX_RETRY) ? 1 + a * P + k : NONE;
        t_x   = 1 + MAX_RETRY * P + TIMEOUT - 1;
        t_end = t_x;
        if (t_p < t_end) t_end = t_p;
        if (t_ab < t_end) t_end = t_ab;
        ea  = (t_ab == t_end);
        ep  = !ea && (t_p == t_end);
        ef  = !ep;
        i   = (t_end - 1) / P;
        off = (t_end - 1) % P;
        er  = (off >= TIMEOUT) ? i + 1 : i;
        edt = t_end + 1;
    endtask

    task automatic run_case(input int a, input int k, input int t_ab, input bit noise,
                            input int bs_t, input bit ep, input bit ef, input bit ea,
                            input int er, input int edt);
        int t_end;
        t_end = edt - 1;
        for (int t = 0; t <= edt + 2; t++) begin
            @(posedge clock);
            #1;
            start        = (t == 0) || (t == bs_t);
            from_up_pass = (t != t_ab);
            chain_ret    = ((a <= MAX_RETRY) && (t == 1 + a * P + k)) || (noise && in_gap(t));
            @(negedge clock);
            if (t >= 1) begin
                chk("to_down_pass", to_down_pass, int'(in_drive(t) && (t <= t_end)));
                chk("busy", busy, int'(t <= edt));
                chk("done", done, int'(t == edt));
            end
            if (t == 1)
                chk("verdict_cleared", {pass, fail, abort}, (edt == 1) ? -1 : 0);
            if (t == edt || t == edt + 2) begin
                chk("pass", pass, ep);
                chk("fail", fail, ef);
                chk("abort", abort, ea);
                chk("retry_cnt", retry_cnt, er);
`ifdef TU_PASS_LAUNCH_STAT_EN
                chk("lat_cnt", lat_cnt, edt + 1);
`endif
            end
        end
        start     = 1'b0;
        chain_ret = 1'b0;
    endtask

    typedef struct {
        int a; int k; int t_ab; bit noise; int bs_t;
        bit ep; bit ef; bit ea; int er; int edt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit ep, ef, ea;
        int er, edt, a, k, t_ab, bs_t;
        bit noise;

        //            a  k  t_ab  nz bs   p  f  ab r  done
        tbl[0] = '{0, 3, NONE, 0, -1, 1, 0, 0, 0, 5};   // immediate pass
        tbl[1] = '{1, 2, NONE, 0, 10, 1, 0, 0, 1, 15};  // retry then pass
        tbl[2] = '{3, 0, NONE, 0, -1, 0, 1, 0, 2, 31};  // retries exhausted
        tbl[3] = '{3, 0, 4,    0, -1, 0, 1, 1, 0, 5};   // abort in DRIVE cycle 4
        tbl[4] = '{0, 7, NONE, 0, 3,  1, 0, 0, 0, 9};   // pass on timeout cycle
        tbl[5] = '{2, 7, NONE, 0, -1, 1, 0, 0, 2, 31};  // pass on final timeout
        tbl[6] = '{3, 0, 10,   0, -1, 0, 1, 1, 1, 11};  // abort in GAP
        tbl[7] = '{0, 3, 4,    0, -1, 0, 1, 1, 0, 5};   // abort beats pass
        tbl[8] = '{2, 0, NONE, 1, -1, 1, 0, 0, 2, 24};  // chain_ret in gaps ignored
        tbl[9] = '{3, 0, 8,    0, -1, 0, 1, 1, 0, 9};   // abort beats timeout

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {to_down_pass, busy, done, pass, fail, abort, retry_cnt}, 0);
`ifdef TU_PASS_LAUNCH_STAT_EN
        chk("reset_lat", lat_cnt, 0);
`endif
        @(posedge clock);
        #1 rst = 1'b0;

        // start without permit is ignored
        @(posedge clock);
        #1 start = 1'b1; from_up_pass = 1'b0;
        @(posedge clock);
        #1 start = 1'b0; from_up_pass = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("ignored_start_busy", busy, 0);
            chk("ignored_start_tdp", to_down_pass, 0);
            @(posedge clock);
        end

        for (int i = 0; i < 10; i++)
            run_case(tbl[i].a, tbl[i].k, tbl[i].t_ab, tbl[i].noise, tbl[i].bs_t,
                     tbl[i].ep, tbl[i].ef, tbl[i].ea, tbl[i].er, tbl[i].edt);

        // async reset in the middle of the first gap
        @(posedge clock);
        #1 start = 1'b1; from_up_pass = 1'b1; chain_ret = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            @(posedge clock);
            #1 start = 1'b0;
        end
        @(negedge clock);
        chk("gap_tdp_low", to_down_pass, 0);
        chk("gap_retry", retry_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", {to_down_pass, busy, done, pass, fail, abort, retry_cnt}, 0);
        @(posedge clock);
        #1 rst = 1'b0;
        @(negedge clock);
        chk("after_reset_busy", busy, 0);

        // randomized runs against the event-time model
        for (int n = 0; n < 40; n++) begin
            a     = $urandom_range(0, MAX_RETRY + 1);
            k     = $urandom_range(0, TIMEOUT - 1);
            t_ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 32) : NONE;
            noise = $urandom_range(0, 1);
            ref_model(a, k, t_ab, ep, ef, ea, er, edt);
            bs_t  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, edt) : -1;
            run_case(a, k, t_ab, noise, bs_t, ep, ef, ea, er, edt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tu_pass_launch.md
Name: tu_pass_launch

Overview:
- Launch/supervise stage placed directly upstream of a test-unit chain.
- Drives the chain's first `from_up_pass` input via its own `to_down_pass` output.
- Watches the chain's final pass return, applies per-attempt timeout and bounded retry, then reports a registered pass/fail verdict.
- Gated by its own upstream `from_up_pass`, so launchers can themselves be chained.

Parameters:
- TIMEOUT, 256, cycles per attempt to wait for chain_ret before declaring attempt timed out (>=2)
- MAX_RETRY, 3, retries after the first attempt (0 = single attempt)
- GAP_CYC, 4, cycles to_down_pass is held low between attempts (>=1)
- CW, 16, width of internal cycle counters (must hold TIMEOUT and GAP_CYC)

Ports:
- clock  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- from_up_pass  input  1  upstream permit; launch allowed only while high
- start  input  1  single-cycle launch request
- chain_ret  input  1  pass level returned from end of downstream chain
- to_down_pass  output  1  level driven into downstream chain's from_up_pass
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when verdict is reached
- pass  output  1  sticky verdict: chain passed
- fail  output  1  sticky verdict: timeout exhausted or aborted
- abort  output  1  sticky: fail was caused by from_up_pass dropping
- retry_cnt  output  $clog2(MAX_RETRY+1) (min 1)  retries consumed in current/last run

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0. Timers cleared.
- All outputs are registered.
- FSM states: IDLE, DRIVE, GAP, DONE.
- IDLE
  - start && from_up_pass → DRIVE.
  - On that edge: pass, fail, abort, retry_cnt cleared; timer cleared.
  - to_down_pass=1 from the next cycle.
  - start while from_up_pass=0 is ignored.
- DRIVE
  - to_down_pass=1; timer increments each cycle.
  - chain_ret=1 → DONE with pass=1. Sampled from the first DRIVE cycle onward.
  - Timer reaches TIMEOUT-1 with chain_ret=0:
    - retry_cnt < MAX_RETRY → GAP; retry_cnt+1; timer cleared.
    - otherwise → DONE with fail=1.
  - chain_ret and timeout in the same cycle: pass wins.
- GAP
  - to_down_pass=0 for exactly GAP_CYC cycles, then → DRIVE with timer cleared.
  - chain_ret is ignored in GAP.
- Abort
  - from_up_pass=0 in DRIVE or GAP → DONE with fail=1, abort=1.
  - to_down_pass drops on the next edge.
  - Abort takes priority over pass and timeout in the same cycle.
- DONE (one cycle)
  - done=1; to_down_pass=0; → IDLE.
  - pass/fail/abort/retry_cnt hold until the next accepted start.
- start while busy is ignored (no queuing).
- Latency:
  - start → to_down_pass rise: 1 cycle.
  - chain_ret rise → done pulse: 1 cycle.
  - Worst case start → done: (MAX_RETRY+1)·TIMEOUT + MAX_RETRY·GAP_CYC + 2.
- pass and fail are never both 1.
- rst asserted mid-run: immediate return to IDLE, all outputs 0.

Optional Feature:
- Macro: TU_PASS_LAUNCH_STAT_EN.
- Defined:
  - Adds output `lat_cnt` [CW-1:0]: total cycles from accepted start to done.
  - Saturates at all-ones; cleared on accepted start.
  - Valid and held from the done pulse until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package `tu_pkg`:
  - state enum `tu_launch_st_e` {IDLE, DRIVE, GAP, DONE}.
  - verdict struct `tu_verdict_t` {pass, fail, abort}.
  - function `tu_cnt_w(n)` for counter widths.
- One sub-module `tu_cyc_timer`: clearable up-counter with terminal-count flag, reused for both TIMEOUT and GAP_CYC.
- FSM and verdict registers stay in the top.

Test Plan (TIMEOUT=8, MAX_RETRY=2, GAP_CYC=3 unless noted):
- Immediate pass
  - Stimulus: start with from_up_pass=1; chain_ret=1 three cycles after to_down_pass rises.
  - Response: done one cycle later; pass=1, retry_cnt=0; to_down_pass low after DONE.
- Retry then pass
  - Stimulus: no chain_ret on attempt 1; chain_ret=1 on attempt 2.
  - Response: to_down_pass high 8, low 3, high again; pass=1, retry_cnt=1.
- Exhausted retries
  - Stimulus: chain_ret never rises.
  - Response: three 8-cycle drive windows; done at cycle 8·3+3·2+2=32; fail=1, retry_cnt=2, abort=0.
- Abort
  - Stimulus: drop from_up_pass in cycle 4 of DRIVE.
  - Response: next edge fail=1, abort=1, to_down_pass=0.
  - Also: start with from_up_pass=0 is ignored (busy stays 0).
- Simultaneous events
  - Stimulus: chain_ret=1 exactly on the timeout cycle.
  - Response: pass=1.
  - Also: start pulsed while busy has no effect.
  - Also: async rst mid-GAP clears all outputs within the same cycle.
- With TU_PASS_LAUNCH_STAT_EN
  - Check: lat_cnt equals the measured start-to-done cycle count in the first three scenarios.
